// File: rtl/sha3_512_padder.sv
// Purpose : packs a byte-granular 64-bit LE word stream into 576-bit Keccak rate blocks, applies pad10*1, feeds the Sha3512 core.
// Latency : 1 word/cycle in FILL; last word -> PAD (1) -> SEND (1) -> WAIT (>= 2, set by core busy); outDone on WAIT exit.
// Backpr. : outWordReady is high only in FILL; while the core is busy (WAIT) no word is accepted and the block is held.
//
// Ports:
//   inClk, inRstN            clock (rising edge), asynchronous active-low reset
//   inStart                  begin a new message (honoured in IDLE only)
//   inWordValid/outWordReady word handshake; inWord byte 0 at bits [7:0]
//   inWordBytes, inLast      valid byte count (0..8) of the last word, end-of-message flag
//   outCoreInit, outCoreWr   core inInit / inDataWr strobes
//   outCoreData              core inData; always mirrors the block buffer
//   inCoreBusy               core outBusy
//   outBusy                  high whenever not IDLE
//   outDone                  one-cycle pulse when the final block has been absorbed
//
// Build option: define SHA3_FIPS202_PAD_EN for the FIPS 202 SHA3-512 pad byte (0x06);
// default is the original Keccak-512 pad byte (0x01).

module sha3_512_padder (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inStart,
    input  logic         inWordValid,
    input  logic [63:0]  inWord,
    input  logic [3:0]   inWordBytes,
    input  logic         inLast,
    output logic         outWordReady,
    output logic         outCoreInit,
    output logic         outCoreWr,
    output logic [575:0] outCoreData,
    input  logic         inCoreBusy,
    output logic         outBusy,
    output logic         outDone
);

`ifdef SHA3_FIPS202_PAD_EN
    localparam logic [7:0] PadByte = 8'h06;
`else
    localparam logic [7:0] PadByte = 8'h01;
`endif

    localparam logic [6:0] RateBytes = 7'd72;
    localparam logic [3:0] LastWordIdx = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StFill,
        StPad,
        StSend,
        StWait
    } state_t;

    state_t         state;
    state_t         nextState;

    logic [575:0]   buffer;
    logic [3:0]     wordIdx;
    logic [6:0]     padPos;
    logic           lastFlag;
    logic           padPending;
    logic           waitGuard;

    logic [3:0]     bytesEff;
    logic [63:0]    maskedWord;
    logic [6:0]     fillPos;
    logic [9:0]     wordBase;
    logic [575:0]   padVec;
    logic           coreIdle;

    // Byte counts above 8 are meaningless for a 64-bit word; treat them as a full word.
    assign bytesEff = (inWordBytes > 4'd8) ? 4'd8 : inWordBytes;

    // Message length so far if the current word ends the message.
    assign fillPos  = {wordIdx, 3'b000} + {3'b000, bytesEff};
    assign wordBase = {wordIdx, 6'b000000};

    // Bytes past the valid count of a last word are stored as zero so the
    // pad byte can simply be XORed in afterwards.
    always_comb begin
        maskedWord = inWord;
        if (inLast) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) >= bytesEff) begin
                    maskedWord[8*b +: 8] = 8'h00;
                end
            end
        end
    end

    // Pad byte at padPos plus the closing 0x80 at byte 71. Using XOR for both
    // makes the p = 71 case merge naturally into pad|0x80.
    assign padVec = ({568'd0, PadByte} << {padPos, 3'b000}) ^ {8'h80, 568'd0};

    // The first WAIT cycle ignores busy: the core may not have raised it yet.
    assign coreIdle = (state == StWait) && !waitGuard && !inCoreBusy;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        nextState    = state;
        outWordReady = 1'b0;
        outCoreInit  = 1'b0;
        outCoreWr    = 1'b0;
        outDone      = 1'b0;
        unique case (state)
            StIdle: begin
                if (inStart) begin
                    nextState = StInit;
                end
            end
            StInit: begin
                outCoreInit = 1'b1;
                nextState   = StFill;
            end
            StFill: begin
                outWordReady = 1'b1;
                if (inWordValid) begin
                    if (inLast) begin
                        // A last word that exactly fills the rate leaves no room
                        // for padding: send it and follow with a pad-only block.
                        nextState = (fillPos == RateBytes) ? StSend : StPad;
                    end else if (wordIdx == LastWordIdx) begin
                        nextState = StSend;
                    end
                end
            end
            StPad: begin
                nextState = StSend;
            end
            StSend: begin
                outCoreWr = 1'b1;
                nextState = StWait;
            end
            StWait: begin
                if (coreIdle) begin
                    if (padPending) begin
                        nextState = StPad;
                    end else if (lastFlag) begin
                        outDone   = 1'b1;
                        nextState = StIdle;
                    end else begin
                        nextState = StFill;
                    end
                end
            end
            default: begin
                nextState = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block buffer and message bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            buffer     <= '0;
            wordIdx    <= '0;
            padPos     <= '0;
            lastFlag   <= 1'b0;
            padPending <= 1'b0;
            waitGuard  <= 1'b0;
        end else begin
            unique case (state)
                StInit: begin
                    buffer     <= '0;
                    wordIdx    <= '0;
                    padPos     <= '0;
                    lastFlag   <= 1'b0;
                    padPending <= 1'b0;
                end
                StFill: begin
                    if (inWordValid) begin
                        buffer[wordBase +: 64] <= maskedWord;
                        if (inLast) begin
                            padPos   <= fillPos;
                            lastFlag <= 1'b1;
                            if (fillPos == RateBytes) begin
                                padPending <= 1'b1;
                            end
                        end else if (wordIdx != LastWordIdx) begin
                            wordIdx <= wordIdx + 4'd1;
                        end
                    end
                end
                StPad: begin
                    buffer     <= buffer ^ padVec;
                    padPending <= 1'b0;
                end
                StSend: begin
                    waitGuard <= 1'b1;
                end
                StWait: begin
                    if (waitGuard) begin
                        waitGuard <= 1'b0;
                    end else if (!inCoreBusy) begin
                        if (padPending) begin
                            // Pad-only block: padding starts at byte 0.
                            buffer <= '0;
                            padPos <= '0;
                        end else if (!lastFlag) begin
                            buffer  <= '0;
                            wordIdx <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign outCoreData = buffer;
    assign outBusy     = (state != StIdle);

endmodule

// File: tb/tb_sha3_512_padder.sv
// Bench for sha3_512_padder: a small core model consumes blocks and raises busy,
// a scoreboard queue holds the expected padded blocks per message.
`timescale 1ns/1ps

module tb_sha3_512_padder;

`ifdef SHA3_FIPS202_PAD_EN
    localparam logic [7:0] PAD = 8'h06;
`else
    localparam logic [7:0] PAD = 8'h01;
`endif

    logic         inClk = 1'b0;
    logic         inRstN;
    logic         inStart;
    logic         inWordValid;
    logic [63:0]  inWord;
    logic [3:0]   inWordBytes;
    logic         inLast;
    logic         outWordReady;
    logic         outCoreInit;
    logic         outCoreWr;
    logic [575:0] outCoreData;
    logic         inCoreBusy;
    logic         outBusy;
    logic         outDone;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int writeCount  = 0;
    int busyCycles  = 0;
    int busyLeft    = 0;

    logic [575:0] sbQ[$];
    logic [7:0]   msgBuf [0:143];

    sha3_512_padder dut (
        .inClk        (inClk),
        .inRstN       (inRstN),
        .inStart      (inStart),
        .inWordValid  (inWordValid),
        .inWord       (inWord),
        .inWordBytes  (inWordBytes),
        .inLast       (inLast),
        .outWordReady (outWordReady),
        .outCoreInit  (outCoreInit),
        .outCoreWr    (outCoreWr),
        .outCoreData  (outCoreData),
        .inCoreBusy   (inCoreBusy),
        .outBusy      (outBusy),
        .outDone      (outDone)
    );

    always #5 inClk = ~inClk;

    // Everything in the bench happens 1ns after the falling edge.
    task automatic tick();
        @(negedge inClk);
        #1;
    endtask

    // Core model: checks each written block against the scoreboard and holds
    // busy for busyCycles cycles afterwards. Also counts done pulses.
    initial begin
        logic [575:0] exp;
        inCoreBusy = 1'b0;
        forever begin
            @(negedge inClk);
            if (busyLeft > 0) begin
                busyLeft = busyLeft - 1;
                if (busyLeft == 0) inCoreBusy = 1'b0;
            end
            #1;
            if (outDone === 1'b1) doneCount++;
            if (outCoreWr === 1'b1) begin
                writeCount++;
                assertCount++;
                if (sbQ.size() == 0) begin
                    failCount++;
                    $display("FAIL unexpected_write: got core write with data %h, required no write", outCoreData);
                end else begin
                    exp = sbQ.pop_front();
                    if (outCoreData !== exp) begin
                        failCount++;
                        $display("FAIL block_data: got %h required %h", outCoreData, exp);
                    end
                end
                busyLeft   = busyCycles;
                inCoreBusy = (busyCycles > 0);
            end
        end
    end

    // Reference pad10*1: append the pad byte, zero-fill to a rate multiple,
    // close with 0x80 in the last byte of the last block.
    task automatic pushExpected(input int len);
        logic [7:0]   pb [0:215];
        logic [575:0] blk;
        int total;
        total = (len / 72 + 1) * 72;
        for (int i = 0; i < total; i++) pb[i] = (i < len) ? msgBuf[i] : 8'h00;
        pb[len]       = pb[len] ^ PAD;
        pb[total - 1] = pb[total - 1] ^ 8'h80;
        for (int b = 0; b < total / 72; b++) begin
            blk = '0;
            for (int j = 0; j < 72; j++) blk[8*j +: 8] = pb[72*b + j];
            sbQ.push_back(blk);
        end
    endtask

    task automatic sendWord(input logic [63:0] w, input logic [3:0] nb, input logic last);
        int waitCnt;
        waitCnt     = 0;
        inWordValid = 1'b1;
        inWord      = w;
        inWordBytes = nb;
        inLast      = last;
        while (outWordReady !== 1'b1 && waitCnt < 200) begin
            tick();
            waitCnt++;
        end
        if (waitCnt >= 200) begin
            assertCount++;
            failCount++;
            $display("FAIL word_ready_timeout: got outWordReady=%b after %0d cycles, required 1", outWordReady, waitCnt);
        end
        tick();
        inWordValid = 1'b0;
        inLast      = 1'b0;
    endtask

    task automatic runMessage(input int len, input int busy, input bit pushModel, input bit checkStall);
        int          nWords;
        int          d0;
        int          waitCnt;
        int          idx;
        logic [63:0] w;
        logic [3:0]  nb;
        bit          last;
        bit          stallBad;
        busyCycles = busy;
        if (pushModel) pushExpected(len);
        d0 = doneCount;
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        assertCount++;
        if (outCoreInit !== 1'b1 || outBusy !== 1'b1) begin
            failCount++;
            $display("FAIL init_pulse: got init=%b busy=%b, required init=1 busy=1", outCoreInit, outBusy);
        end
        nWords = (len == 0) ? 1 : (len + 7) / 8;
        for (int k = 0; k < nWords; k++) begin
            for (int j = 0; j < 8; j++) begin
                idx = 8 * k + j;
                w[8*j +: 8] = (idx < len) ? msgBuf[idx] : 8'($urandom);
            end
            last = (k == nWords - 1);
            nb   = last ? 4'(len - 8 * k) : 4'($urandom_range(0, 8));
            if (checkStall && k == 9) begin
                inWordValid = 1'b1;
                inWord      = w;
                inWordBytes = nb;
                inLast      = last;
                stallBad    = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    tick();
                    if (outWordReady !== 1'b0 || inCoreBusy !== 1'b1) stallBad = 1'b1;
                end
                assertCount++;
                if (stallBad) begin
                    failCount++;
                    $display("FAIL stall_ready: got outWordReady=%b coreBusy=%b during busy, required ready=0", outWordReady, inCoreBusy);
                end
            end
            sendWord(w, nb, last);
        end
        waitCnt = 0;
        while (outDone !== 1'b1 && waitCnt < 2000) begin
            tick();
            waitCnt++;
        end
        assertCount++;
        if (waitCnt >= 2000) begin
            failCount++;
            $display("FAIL done_timeout: got no outDone in %0d cycles, required one", waitCnt);
        end
        tick();
        assertCount++;
        if (outBusy !== 1'b0) begin
            failCount++;
            $display("FAIL idle_after_done: got outBusy=%b, required 0", outBusy);
        end
        assertCount++;
        if (doneCount - d0 != 1) begin
            failCount++;
            $display("FAIL done_count: got %0d done pulses, required 1", doneCount - d0);
        end
        assertCount++;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("FAIL blocks_pending: got %0d unwritten blocks, required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_reset();
        inRstN      = 1'b0;
        inStart     = 1'b0;
        inWordValid = 1'b0;
        inWord      = '0;
        inWordBytes = '0;
        inLast      = 1'b0;
        #3;
        assertCount++;
        if ({outWordReady, outCoreInit, outCoreWr, outBusy, outDone} !== 5'b0) begin
            failCount++;
            $display("FAIL reset_ctrl: got ready/init/wr/busy/done=%b, required 00000",
                     {outWordReady, outCoreInit, outCoreWr, outBusy, outDone});
        end
        assertCount++;
        if (outCoreData !== '0) begin
            failCount++;
            $display("FAIL reset_data: got %h, required 0", outCoreData);
        end
        tick();
        tick();
        inRstN = 1'b1;
        tick();
        assertCount++;
        if (outBusy !== 1'b0 || outWordReady !== 1'b0) begin
            failCount++;
            $display("FAIL idle_hold: got busy=%b ready=%b without start, required 0 0", outBusy, outWordReady);
        end
    endtask

    task automatic test_haslo();
        string        s;
        logic [575:0] blk;
        s = "Haslo:KajaK";
        for (int i = 0; i < 11; i++) msgBuf[i] = s[i];
        blk = '0;
        blk[575:568] = 8'h80;
        blk[95:0]    = {PAD, 24'h4B616A, 64'h614B3A6F6C736148};
        sbQ.push_back(blk);
        runMessage(11, 5, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        logic [575:0] blk;
        blk = '0;
        blk[575:568] = 8'h80;
        blk[7:0]     = PAD;
        sbQ.push_back(blk);
        runMessage(0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_full_rate();
        for (int i = 0; i < 72; i++) msgBuf[i] = 8'($urandom);
        runMessage(72, 4, 1'b1, 1'b0);
    endtask

    task automatic test_71_bytes();
        for (int i = 0; i < 71; i++) msgBuf[i] = 8'($urandom);
        runMessage(71, 2, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 80; i++) msgBuf[i] = 8'($urandom);
        runMessage(80, 20, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 144; i++) msgBuf[i] = 8'($urandom);
        runMessage(20, 0, 1'b1, 1'b0);
        runMessage(8, 0, 1'b1, 1'b0);
        runMessage(144, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        int w0;
        int waitCnt;
        for (int i = 0; i < 5; i++) msgBuf[i] = 8'($urandom);
        busyCycles = 30;
        pushExpected(5);
        w0 = writeCount;
        inStart = 1'b1;
        tick();
        inStart = 1'b0;
        sendWord({24'h0, msgBuf[4], msgBuf[3], msgBuf[2], msgBuf[1], msgBuf[0]}, 4'd5, 1'b1);
        waitCnt = 0;
        while (writeCount == w0 && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        tick();
        tick();
        tick();
        assertCount++;
        if (outBusy !== 1'b1 || outCoreData === '0) begin
            failCount++;
            $display("FAIL pre_reset_wait: got busy=%b data=%h, required busy=1 and a held block", outBusy, outCoreData);
        end
        #2;
        inRstN = 1'b0;
        #1;
        assertCount++;
        if ({outWordReady, outCoreInit, outCoreWr, outBusy, outDone} !== 5'b0) begin
            failCount++;
            $display("FAIL midwait_reset_ctrl: got ready/init/wr/busy/done=%b, required 00000",
                     {outWordReady, outCoreInit, outCoreWr, outBusy, outDone});
        end
        assertCount++;
        if (outCoreData !== '0) begin
            failCount++;
            $display("FAIL midwait_reset_data: got %h, required 0", outCoreData);
        end
        tick();
        inRstN = 1'b1;
        waitCnt = 0;
        while (inCoreBusy === 1'b1 && waitCnt < 100) begin
            tick();
            waitCnt++;
        end
        sbQ.delete();
        for (int i = 0; i < 71; i++) msgBuf[i] = 8'($urandom);
        runMessage(71, 3, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_haslo();
        test_empty();
        test_full_rate();
        test_71_bytes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
